// File: rtl/sub_pix_pkg.sv
// Shared defaults, framing payload and arithmetic helpers for the sub-pixel delay lanes.
package sub_pix_pkg;

  localparam int unsigned NL_DEF     = 4;
  localparam int unsigned DATA_W_DEF = 14;
  localparam int unsigned FRAC_W_DEF = 8;

  typedef struct packed {
    logic sol;
    logic eol;
  } frame_t;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  // Round-half-up arithmetic right shift; sh must be >= 1.
  function automatic logic signed [31:0] round_shr(input logic signed [31:0] p,
                                                   input int unsigned sh);
    logic signed [31:0] bias;
    bias = 32'sd1 <<< (sh - 1);
    return (p + bias) >>> sh;
  endfunction

endpackage

// File: rtl/sub_pix_delay_lanes_if.sv
// Stream, framing and control bundle between the sample packer, this block and gain prediction.
interface sub_pix_delay_lanes_if
  import sub_pix_pkg::*;
#(
  parameter int unsigned NL     = NL_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [NL*DATA_W-1:0]   in_data;
  logic                   in_sol;
  logic                   in_eol;
  logic [FRAC_W-1:0]      fract_steps;
  logic                   shift_dir;
  logic                   out_valid;
  logic                   out_ready;
  logic [NL*DATA_W-1:0]   out_data;
  logic                   out_sol;
  logic                   out_eol;
  logic                   err_sticky;

  modport master (
    output in_valid, in_data, in_sol, in_eol, fract_steps, shift_dir, out_ready,
    input  in_ready, out_valid, out_data, out_sol, out_eol, err_sticky
  );

  modport slave (
    input  in_valid, in_data, in_sol, in_eol, fract_steps, shift_dir, out_ready,
    output in_ready, out_valid, out_data, out_sol, out_eol, err_sticky
  );

endinterface

// File: rtl/sub_pix_lane_interp.sv
// One lane of the fractional shift: registered product, then registered rounded sum.
module sub_pix_lane_interp
  import sub_pix_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_prev,
  input  logic [DATA_W-1:0] i_next,
  input  logic [FRAC_W-1:0] i_frac,
  input  logic              i_dir,
  output logic [DATA_W-1:0] o_out
);

  localparam int unsigned PW = DATA_W + FRAC_W + 1;

  logic [DATA_W-1:0]        w_nb;
  logic signed [DATA_W:0]   w_d;
  logic signed [PW-1:0]     w_dx;
  logic signed [PW-1:0]     w_fx;
  logic signed [PW-1:0]     w_p;
  logic [DATA_W-1:0]        r_a;
  logic signed [PW-1:0]     r_p;

  always_comb begin
    w_nb = i_dir ? i_prev : i_next;
    w_d  = $signed({1'b0, w_nb}) - $signed({1'b0, i_a});
    w_dx = {{FRAC_W{w_d[DATA_W]}}, w_d};
    w_fx = {{(DATA_W + 1){1'b0}}, i_frac};
    w_p  = w_dx * w_fx;
  end

  // Result is a convex combination of a and its neighbour, so wrap-around addition is exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_p   <= '0;
      o_out <= '0;
    end else if (i_en) begin
      r_a   <= i_a;
      r_p   <= w_p;
      o_out <= r_a + DATA_W'(round_shr(32'(r_p), FRAC_W));
    end
  end

endmodule

// File: rtl/sub_pix_delay_lanes.sv
// NL-lane sub-pixel shifter: cross-beat neighbour window, line-edge replication,
// framing-error detection and a two-stage per-lane interpolation pipeline.
module sub_pix_delay_lanes
  import sub_pix_pkg::*;
#(
  parameter int unsigned NL     = NL_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input logic                  clk,
  input logic                  reset,
  sub_pix_delay_lanes_if.slave bus
);

  logic [NL-1:0][DATA_W-1:0] w_in_lanes;
  logic [NL-1:0][DATA_W-1:0] w_out_lanes;
  logic [NL-1:0][DATA_W-1:0] r_h;
  logic                      r_h_valid;
  frame_t                    r_h_fr;
  logic [DATA_W-1:0]         r_prev0;
  logic                      r_flush;
  logic                      r_rdy_ok;
  logic [FRAC_W-1:0]         r_frac;
  logic                      r_dir;
  logic                      r_err;
  logic                      r_v1;
  frame_t                    r_fr1;
  logic                      r_out_valid;
  frame_t                    r_fr_out;

  logic                      w_en;
  logic                      w_ready;
  logic                      w_acc;
  logic                      w_as_sol;
  logic                      w_err;
  logic                      w_flush;
  logic                      w_rel;
  logic [DATA_W-1:0]         w_cross;

  // With in_ready high, H valid means an unterminated line is open.
  always_comb begin
    w_in_lanes = bus.in_data;
    w_en       = bus.out_ready | ~r_out_valid;
    w_ready    = w_en & ~r_flush & r_rdy_ok & ~reset;
    w_acc      = bus.in_valid & w_ready;
    w_as_sol   = bus.in_sol | ~r_h_valid;
    w_err      = w_acc & (bus.in_sol == r_h_valid);
    w_flush    = w_en & r_flush;
    w_rel      = w_flush | (w_acc & r_h_valid & ~bus.in_sol);
    w_cross    = r_flush ? r_h[NL-1] : w_in_lanes[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h         <= '0;
      r_h_valid   <= 1'b0;
      r_h_fr      <= '0;
      r_prev0     <= '0;
      r_flush     <= 1'b0;
      r_rdy_ok    <= 1'b0;
      r_frac      <= '0;
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
      r_v1        <= 1'b0;
      r_fr1       <= '0;
      r_out_valid <= 1'b0;
      r_fr_out    <= '0;
    end else begin
      r_rdy_ok <= 1'b1;
      if (w_err) r_err <= 1'b1;
      if (w_flush) begin
        r_h_valid <= 1'b0;
        r_flush   <= 1'b0;
      end
      // An errored beat overwrites H, which drops the beat it held.
      if (w_acc) begin
        r_h        <= w_in_lanes;
        r_h_valid  <= 1'b1;
        r_h_fr.sol <= bus.in_sol;
        r_h_fr.eol <= bus.in_eol;
        r_flush    <= bus.in_eol;
        r_prev0    <= w_as_sol ? w_in_lanes[0] : r_h[NL-1];
        if (w_as_sol) begin
          r_frac <= bus.fract_steps;
          r_dir  <= bus.shift_dir;
        end
      end
      if (w_en) begin
        r_v1        <= w_rel;
        r_fr1       <= r_h_fr;
        r_out_valid <= r_v1;
        r_fr_out    <= r_fr1;
      end
    end
  end

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    logic [DATA_W-1:0] w_prev;
    logic [DATA_W-1:0] w_next;

    if (gi == 0) begin : g_prev_edge
      assign w_prev = r_prev0;
    end else begin : g_prev_in
      assign w_prev = r_h[gi-1];
    end

    if (gi == NL - 1) begin : g_next_edge
      assign w_next = w_cross;
    end else begin : g_next_in
      assign w_next = r_h[gi+1];
    end

    sub_pix_lane_interp #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_en),
      .i_a    (r_h[gi]),
      .i_prev (w_prev),
      .i_next (w_next),
      .i_frac (r_frac),
      .i_dir  (r_dir),
      .o_out  (w_out_lanes[gi])
    );

    assign bus.out_data[lane_lo(gi, DATA_W) +: DATA_W] = w_out_lanes[gi];
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sol    = r_fr_out.sol;
  assign bus.out_eol    = r_fr_out.eol;
  assign bus.err_sticky = r_err;

endmodule
